// File: rtl/cntr_pkg.sv
// Shared definitions for the counter command sequencer: op codes, FSM states
// and a width helper used to size the command argument.
package cntr_pkg;

    typedef enum logic [1:0] {
        OP_LOAD = 2'd0,
        OP_UP   = 2'd1,
        OP_DOWN = 2'd2,
        OP_WAIT = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        SEQ_IDLE    = 2'd0,
        SEQ_EX_LD   = 2'd1,
        SEQ_EX_CNT  = 2'd2,
        SEQ_EX_WAIT = 2'd3
    } seq_state_e;

    function automatic int unsigned max_w(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO with flush; pointers carry an extra wrap bit so
// full and empty are distinguished without a separate occupancy counter.
module cmd_fifo #(
    parameter int unsigned W     = 10,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic         w_push;
    logic         w_pop;

    assign w_push = push && !full && !flush;
    assign w_pop  = pop && !empty && !flush;

    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign dout  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/cntr8_seq.sv
// Command sequencer: pops queued LOAD/UP/DOWN/WAIT commands and drives the
// counter's load/enable/direction controls as Moore outputs of the FSM state.
module cntr8_seq
    import cntr_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LEN_W  = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              halt,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic [1:0]                        cmd_op,
    input  logic [max_w(DATA_W, LEN_W)-1:0]   cmd_arg,
    output logic                              cnt_load,
    output logic [DATA_W-1:0]                 cnt_d_in,
    output logic                              cnt_en,
    output logic                              cnt_up,
    output logic                              done,
    output logic                              busy,
    output logic [1:0]                        o_state
);

    localparam int unsigned ARG_W = max_w(DATA_W, LEN_W);
    localparam int unsigned FW    = 2 + ARG_W;

    logic [FW-1:0]    w_fifo_dout;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    op_e              w_head_op;
    logic [ARG_W-1:0] w_head_arg;

    seq_state_e       r_state,  w_state_nx;
    op_e              r_op,     w_op_nx;
    logic [LEN_W-1:0] r_rem,    w_rem_nx;
    logic [DATA_W-1:0] r_d_in,  w_d_in_nx;
    logic             r_done,   w_done_nx;

    assign cmd_ready  = !w_full && !halt && reset_n;
    assign w_push     = cmd_valid && cmd_ready;
    assign w_head_op  = op_e'(w_fifo_dout[FW-1 -: 2]);
    assign w_head_arg = w_fifo_dout[ARG_W-1:0];

    cmd_fifo #(
        .W     (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (halt),
        .push    (w_push),
        .din     ({cmd_op, cmd_arg}),
        .pop     (w_pop),
        .dout    (w_fifo_dout),
        .full    (w_full),
        .empty   (w_empty)
    );

    always_comb begin
        w_state_nx = r_state;
        w_op_nx    = r_op;
        w_rem_nx   = r_rem;
        w_d_in_nx  = r_d_in;
        w_done_nx  = 1'b0;
        w_pop      = 1'b0;
        case (r_state)
            SEQ_IDLE: begin
                if (!w_empty) begin
                    w_pop    = 1'b1;
                    w_op_nx  = w_head_op;
                    w_rem_nx = w_head_arg[LEN_W-1:0];
                    if (w_head_op == OP_LOAD) begin
                        w_d_in_nx  = w_head_arg[DATA_W-1:0];
                        w_state_nx = SEQ_EX_LD;
                    end else if (w_head_arg[LEN_W-1:0] == '0) begin
                        // zero-length command completes straight from the pop
                        w_done_nx = 1'b1;
                    end else if (w_head_op == OP_WAIT) begin
                        w_state_nx = SEQ_EX_WAIT;
                    end else begin
                        w_state_nx = SEQ_EX_CNT;
                    end
                end
            end
            SEQ_EX_LD: begin
                w_state_nx = SEQ_IDLE;
                w_done_nx  = 1'b1;
            end
            SEQ_EX_CNT, SEQ_EX_WAIT: begin
                if (r_rem == LEN_W'(1)) begin
                    w_state_nx = SEQ_IDLE;
                    w_rem_nx   = '0;
                    w_done_nx  = 1'b1;
                end else begin
                    w_rem_nx = r_rem - LEN_W'(1);
                end
            end
            default: w_state_nx = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= SEQ_IDLE;
            r_op    <= OP_LOAD;
            r_rem   <= '0;
            r_d_in  <= '0;
            r_done  <= 1'b0;
        end else if (halt) begin
            r_state <= SEQ_IDLE;
            r_rem   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_op    <= w_op_nx;
            r_rem   <= w_rem_nx;
            r_d_in  <= w_d_in_nx;
            r_done  <= w_done_nx;
        end
    end

    assign cnt_load = (r_state == SEQ_EX_LD);
    assign cnt_en   = (r_state == SEQ_EX_CNT);
    assign cnt_up   = (r_state == SEQ_EX_CNT) && (r_op == OP_UP);
    assign cnt_d_in = r_d_in;
    assign done     = r_done;
    assign busy     = (r_state != SEQ_IDLE) || !w_empty;
    assign o_state  = r_state;

endmodule

// File: tb/tb_cntr8_seq.sv
// Scoreboard bench for cntr8_seq: directed commands push expected control
// events (with absolute cycle stamps) that a negedge monitor consumes.
module tb_cntr8_seq;
    import cntr_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       halt;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_arg;
    logic       cnt_load;
    logic [7:0] cnt_d_in;
    logic       cnt_en;
    logic       cnt_up;
    logic       done;
    logic       busy;
    logic [1:0] o_state;

    cntr8_seq #(
        .DATA_W (8),
        .LEN_W  (8),
        .DEPTH  (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .halt      (halt),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_arg   (cmd_arg),
        .cnt_load  (cnt_load),
        .cnt_d_in  (cnt_d_in),
        .cnt_en    (cnt_en),
        .cnt_up    (cnt_up),
        .done      (done),
        .busy      (busy),
        .o_state   (o_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        bit         load;
        bit         en;
        bit         up;
        bit         dn;
        logic [7:0] d;
    } exp_t;

    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] ref_cnt = 8'h00;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    task automatic expect_ev(input int c, input bit l, input bit e, input bit u,
                             input bit dn, input logic [7:0] d);
        exp_t x;
        x.cyc = c; x.load = l; x.en = e; x.up = u; x.dn = dn; x.d = d;
        sb.push_back(x);
    endtask

    // Monitor: one scoreboard entry per cycle with any load/enable/done activity.
    initial begin
        exp_t e;
        bit   act;
        forever begin
            @(negedge clk);
            if (cnt_load === 1'b1 && cnt_en === 1'b1) begin
                n_cmp++; n_bad++;
                $display("FAIL load_en_overlap: both high at cycle %0d", cyc);
            end
            if (cnt_up === 1'b1 && cnt_en !== 1'b1) begin
                n_cmp++; n_bad++;
                $display("FAIL up_without_en: cnt_up=1 with cnt_en=0 at cycle %0d", cyc);
            end
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                e = sb.pop_front();
                n_cmp++; n_bad++;
                $display("FAIL missed_event: expected l=%0b e=%0b u=%0b done=%0b at cycle %0d did not occur",
                         e.load, e.en, e.up, e.dn, e.cyc);
            end
            act = (cnt_load === 1'b1) || (cnt_en === 1'b1) || (done === 1'b1);
            if (act) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_event: l=%0b e=%0b u=%0b done=%0b at cycle %0d",
                             cnt_load, cnt_en, cnt_up, done, cyc);
                end else begin
                    e = sb.pop_front();
                    if (e.cyc != cyc || e.load != cnt_load || e.en != cnt_en ||
                        e.up != cnt_up || e.dn != done || (e.load && cnt_d_in !== e.d)) begin
                        n_bad++;
                        $display("FAIL event: got cyc=%0d l=%0b e=%0b u=%0b done=%0b d=0x%0h expected cyc=%0d l=%0b e=%0b u=%0b done=%0b d=0x%0h",
                                 cyc, cnt_load, cnt_en, cnt_up, done, cnt_d_in,
                                 e.cyc, e.load, e.en, e.up, e.dn, e.d);
                    end
                end
                if (cnt_load === 1'b1)     ref_cnt = cnt_d_in;
                else if (cnt_en === 1'b1)  ref_cnt = cnt_up ? ref_cnt + 8'd1 : ref_cnt - 8'd1;
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [7:0] arg, output int acc);
        bit r;
        acc = -1;
        cmd_op = op; cmd_arg = arg; cmd_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            r = cmd_ready;
            @(posedge clk); #1;
            if (r) begin
                acc = cyc;
                break;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        if (acc < 0) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: op=%0d arg=0x%0h not accepted within 100 cycles", op, arg);
        end
        @(negedge clk);
    endtask

    task automatic wait_idle(input string nm);
        for (int k = 0; k < 60; k++) begin
            @(negedge clk); #2;
            if (busy === 1'b0 && done === 1'b0 && sb.size() == 0) break;
        end
        chk({nm, "_busy"}, 32'(busy), 32'd0);
        chk({nm, "_sb_drained"}, 32'(sb.size()), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int a, b, c;
        reset_n = 1'b0; halt = 1'b0; cmd_valid = 1'b1; cmd_op = OP_UP; cmd_arg = 8'h05;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_ready", 32'(cmd_ready), 32'd0);
        chk("rst_load",  32'(cnt_load),  32'd0);
        chk("rst_en",    32'(cnt_en),    32'd0);
        chk("rst_up",    32'(cnt_up),    32'd0);
        chk("rst_d_in",  32'(cnt_d_in),  32'd0);
        chk("rst_done",  32'(done),      32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_state", 32'(o_state),   32'd0);
        @(negedge clk);
        cmd_valid = 1'b0; reset_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);

        // Single LOAD 0xA5
        send(OP_LOAD, 8'hA5, a);
        expect_ev(a + 1, 1, 0, 0, 0, 8'hA5);
        expect_ev(a + 2, 0, 0, 0, 1, 8'h00);
        wait_idle("load");
        chk("load_d_hold", 32'(cnt_d_in), 32'hA5);

        // LOAD 0xA5, UP 3, DOWN 2 back to back
        send(OP_LOAD, 8'hA5, a);
        expect_ev(a + 1, 1, 0, 0, 0, 8'hA5);
        expect_ev(a + 2, 0, 0, 0, 1, 8'h00);
        for (int i = 3; i <= 5; i++) expect_ev(a + i, 0, 1, 1, 0, 8'h00);
        expect_ev(a + 6, 0, 0, 0, 1, 8'h00);
        expect_ev(a + 7, 0, 1, 0, 0, 8'h00);
        expect_ev(a + 8, 0, 1, 0, 0, 8'h00);
        expect_ev(a + 9, 0, 0, 0, 1, 8'h00);
        send(OP_UP, 8'd3, b);
        send(OP_DOWN, 8'd2, c);
        chk("b2b_accept", 32'(c), 32'(a + 2));
        wait_idle("b2b");
        chk("b2b_ref_cnt", 32'(ref_cnt), 32'hA6);

        // Full FIFO behind a WAIT 20
        send(OP_WAIT, 8'd20, a);
        expect_ev(a + 21, 0, 0, 0, 1, 8'h00);
        expect_ev(a + 22, 0, 1, 1, 0, 8'h00);
        expect_ev(a + 23, 0, 0, 0, 1, 8'h00);
        expect_ev(a + 24, 0, 1, 0, 0, 8'h00);
        expect_ev(a + 25, 0, 0, 0, 1, 8'h00);
        expect_ev(a + 26, 1, 0, 0, 0, 8'h3C);
        expect_ev(a + 27, 0, 0, 0, 1, 8'h00);
        expect_ev(a + 28, 0, 0, 0, 1, 8'h00);
        expect_ev(a + 29, 0, 1, 1, 0, 8'h00);
        expect_ev(a + 30, 0, 1, 1, 0, 8'h00);
        expect_ev(a + 31, 0, 0, 0, 1, 8'h00);
        send(OP_UP, 8'd1, b);
        send(OP_DOWN, 8'd1, b);
        send(OP_LOAD, 8'h3C, b);
        send(OP_WAIT, 8'd0, b);
        chk("full_4th_accept", 32'(b), 32'(a + 4));
        chk("full_ready_low", 32'(cmd_ready), 32'd0);
        send(OP_UP, 8'd2, c);
        chk("full_5th_accept", 32'(c), 32'(a + 23));
        wait_idle("full");
        chk("full_d_hold", 32'(cnt_d_in), 32'h3C);

        // Zero-length commands
        send(OP_UP, 8'd0, a);
        expect_ev(a + 1, 0, 0, 0, 1, 8'h00);
        expect_ev(a + 2, 0, 0, 0, 1, 8'h00);
        send(OP_WAIT, 8'd0, b);
        wait_idle("zero");

        // Abort with halt on the 4th enable cycle
        send(OP_UP, 8'd10, a);
        for (int i = 1; i <= 4; i++) expect_ev(a + i, 0, 1, 1, 0, 8'h00);
        send(OP_LOAD, 8'h11, b);
        send(OP_WAIT, 8'd3, b);
        for (int k = 0; k < 20 && cyc < a + 4; k++) @(negedge clk);
        halt = 1'b1;
        @(posedge clk); #1;
        chk("halt_en",    32'(cnt_en),    32'd0);
        chk("halt_done",  32'(done),      32'd0);
        chk("halt_busy",  32'(busy),      32'd0);
        chk("halt_state", 32'(o_state),   32'd0);
        chk("halt_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        halt = 1'b0;
        repeat (6) @(negedge clk);
        wait_idle("halt");
        chk("halt_d_hold", 32'(cnt_d_in), 32'h3C);

        // Abort with reset on the 4th enable cycle
        send(OP_UP, 8'd10, a);
        for (int i = 1; i <= 4; i++) expect_ev(a + i, 0, 1, 1, 0, 8'h00);
        send(OP_LOAD, 8'h11, b);
        send(OP_WAIT, 8'd3, b);
        for (int k = 0; k < 20 && cyc < a + 4; k++) @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk); #1;
        chk("rabort_en",    32'(cnt_en),    32'd0);
        chk("rabort_done",  32'(done),      32'd0);
        chk("rabort_busy",  32'(busy),      32'd0);
        chk("rabort_state", 32'(o_state),   32'd0);
        chk("rabort_ready", 32'(cmd_ready), 32'd0);
        chk("rabort_d_in",  32'(cnt_d_in),  32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        wait_idle("rabort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/cntr8_seq.md
# cntr8_seq

Command sequencer for the 8-bit loadable up/down counter datapath. Accepts queued commands (load, count up N, count down N, wait N) over a valid/ready handshake, buffers them in a small FIFO and drives the counter's load/enable/direction controls cycle by cycle. It sits between the control software or host FSM and the counter slice, so callers never hand-sequence `load` and `inc`.

## Interface
- `DATA_W`, 8: counter data width; width of `cnt_d_in` and of the LOAD argument.
- `LEN_W`, 8: width of the repeat count for UP/DOWN/WAIT.
- `DEPTH`, 4: command FIFO depth; must be a power of two, at least 2.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset_n`  in  1  reset, synchronous and active-low.
- `halt`  in  1  synchronous abort: flush the FIFO and drop the current command.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  FIFO can accept; `!full && !halt && reset_n`.
- `cmd_op`  in  2  0=LOAD, 1=UP, 2=DOWN, 3=WAIT.
- `cmd_arg`  in  max(DATA_W,LEN_W)  LOAD value or repeat count.
- `cnt_load`  out  1  counter parallel load.
- `cnt_d_in`  out  DATA_W  load value; holds the last LOAD argument.
- `cnt_en`  out  1  counter step enable.
- `cnt_up`  out  1  direction when `cnt_en`: 1=up, 0=down.
- `done`  out  1  one-cycle pulse per completed command.
- `busy`  out  1  `state != IDLE || !empty`.
- `o_state`  out  2  current FSM state, for debug.

## Operation
- Accept: a command is written at an edge where `cmd_valid && cmd_ready`. It is visible to the FSM (`!empty`) from the next cycle.
- FSM states:
  - IDLE=0: if `!empty`, pop at the edge and latch op/arg into `cur_op`/`remaining`. LOAD goes to EX_LD. UP/DOWN with arg≠0 go to EX_CNT. WAIT with arg≠0 goes to EX_WAIT. arg=0 stays in IDLE and counts as completed.
  - EX_LD=1: `cnt_load=1` and `cnt_d_in=arg` for exactly one cycle, then IDLE.
  - EX_CNT=2: `cnt_en=1` and `cnt_up=(cur_op==UP)` for exactly `arg` cycles. Decrement `remaining`; leave for IDLE when `remaining==1`.
  - EX_WAIT=3: all counter controls 0 for `arg` cycles, then IDLE.
- Controls are Moore outputs decoded from state. `cnt_en` and `cnt_load` are never both high. `cnt_up` is 0 outside EX_CNT.
- `done` is registered and goes high in the cycle after a command's last execution cycle. For zero-length commands, that is the cycle after the pop.
- IDLE may pop the next command in the same cycle `done` is high.
- Wrap-around of the counter value is the counter's concern; the sequencer never inspects the count.
- Priority, highest first: `reset_n` low, then `halt`, then normal operation.
  - `halt`: FIFO pointers cleared, state goes to IDLE, `remaining` cleared, no `done` for the aborted command. A write presented that cycle is refused.
  - Simultaneous push and pop on a full FIFO: the push is refused (`cmd_ready=0` when full).

## Timing
- Reset values: `cnt_load=0`, `cnt_en=0`, `cnt_up=0`, `cnt_d_in=0`, `done=0`, `busy=0`, `o_state=0`, FIFO empty, `cmd_ready=0` while `reset_n=0`.
- Latency from acceptance into an empty idle block to the first control cycle: 2 edges (write, then pop).
- Per-command occupancy: LOAD takes 1 cycle; UP/DOWN/WAIT take `arg` cycles. Add 1 IDLE/pop cycle per command.
- Reset or halt mid-command: controls low in the first cycle after the edge that samples it.

## Structure
- Shared package `cntr_pkg` holds:
  - op codes `OP_LOAD`, `OP_UP`, `OP_DOWN`, `OP_WAIT`;
  - state encodings `SEQ_IDLE`, `SEQ_EX_LD`, `SEQ_EX_CNT`, `SEQ_EX_WAIT`.
- One sub-module, `cmd_fifo`: synchronous FIFO, width 2+max(DATA_W,LEN_W), depth DEPTH, with `push`/`pop`/`flush`/`full`/`empty`.
- The FSM, counters and output decode live in `cntr8_seq`.

## Test plan
- Reset: `reset_n=0` for 2 edges, with `cmd_valid=1` -> nothing accepted; all outputs 0; `o_state=0`.
- LOAD 0xA5 -> `cnt_load=1`, `cnt_d_in=0xA5` for one cycle, 2 edges after acceptance; `done` the next cycle; `busy` returns to 0.
- Back-to-back UP 3 then DOWN 2 after LOAD 0xA5 -> `cnt_en` 3 cycles with `cnt_up=1`, 1 gap cycle, 2 cycles with `cnt_up=0`; two `done` pulses; reference counter ends at 0xA6.
- Full FIFO: WAIT 20 executing, then push 5 commands -> 4 accepted, `cmd_ready=0` on the 5th until the WAIT completes and a pop frees a slot.
- Zero length: UP 0 then WAIT 0 -> no `cnt_en` cycles; `done` in the cycle after each pop.
- Abort: UP 10 with `halt=1` on its 4th enable cycle, 2 commands queued -> `cnt_en` low the next cycle, no `done`, `busy=0`, queue empty. Repeat with `reset_n=0` instead -> same result plus reset values.
